// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Read-owner encoding and the width of the fairness wait counter.
package dmem_arb_pkg;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_COP  = 1'b1
    } ownerT;

    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Coprocessor starvation counter, used only when DMEM_ARB_FAIRNESS_EN is defined.
// Raises forceCop once the coprocessor has waited MAX_WAIT consecutive cycles.
module dmem_arb_starve_cnt
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic copReq,
    input  logic copGnt,
    output logic forceCop
);

    localparam logic [WAIT_CNT_W-1:0] MAX_CNT = WAIT_CNT_W'(MAX_WAIT);

    logic [WAIT_CNT_W-1:0] waitCount;

    // Counts only uninterrupted waiting; any grant or idle cycle restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            waitCount <= '0;
        end else if (!copReq || copGnt) begin
            waitCount <= '0;
        end else if (waitCount != MAX_CNT) begin
            waitCount <= waitCount + 1'b1;
        end
    end

    assign forceCop = (waitCount == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// Core/coprocessor arbiter for a single-port synchronous data RAM.
// Define DMEM_ARB_FAIRNESS_EN to add a forced coprocessor grant after MAX_WAIT lost cycles.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int N        = 64,
    parameter int AW       = 10,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  core_addr,
    input  logic [N-1:0]  core_writeData,
    input  logic          core_writeEnable,
    input  logic          core_readEnable,
    output logic [N-1:0]  core_readData,
    output logic          core_stall,
    input  logic          cop_req,
    input  logic          cop_we,
    input  logic [N-1:0]  cop_addr,
    input  logic [N-1:0]  cop_wdata,
    output logic          cop_gnt,
    output logic          cop_rvalid,
    output logic [N-1:0]  cop_rdata,
    output logic [AW-1:0] mem_address,
    output logic [N-1:0]  mem_data,
    output logic          mem_rden,
    output logic          mem_wren,
    input  logic [N-1:0]  mem_q
);

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : gBadMaxWait
        $error("dmem_arbiter: MAX_WAIT must be in 1..15");
    end

    logic  coreReq;
    logic  coreGnt;
    logic  copGnt;
    logic  forceCop;
    logic  readPending;
    ownerT readOwner;
    logic  unusedAddrBits;

    // Only the word-address field of each byte address reaches the RAM.
    assign unusedAddrBits = ^{core_addr[N-1:AW+3], core_addr[2:0],
                              cop_addr[N-1:AW+3], cop_addr[2:0]};

    assign coreReq = core_readEnable | core_writeEnable;

`ifdef DMEM_ARB_FAIRNESS_EN
    dmem_arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) uStarveCnt (
        .clk      (clk),
        .reset    (reset),
        .copReq   (cop_req),
        .copGnt   (copGnt),
        .forceCop (forceCop)
    );

    assign core_stall = coreReq & copGnt;
`else
    assign forceCop   = 1'b0;
    assign core_stall = 1'b0;
`endif

    always_comb begin
        coreGnt = 1'b0;
        copGnt  = 1'b0;
        if (!reset) begin
            if (cop_req && (!coreReq || forceCop)) begin
                copGnt = 1'b1;
            end else if (coreReq) begin
                coreGnt = 1'b1;
            end
        end
    end

    // A core request with both enables high is a pure write.
    always_comb begin
        mem_address = '0;
        mem_data    = '0;
        mem_rden    = 1'b0;
        mem_wren    = 1'b0;
        if (coreGnt) begin
            mem_address = core_addr[AW+2:3];
            mem_data    = core_writeData;
            mem_wren    = core_writeEnable;
            mem_rden    = ~core_writeEnable;
        end else if (copGnt) begin
            mem_address = cop_addr[AW+2:3];
            mem_data    = cop_wdata;
            mem_wren    = cop_we;
            mem_rden    = ~cop_we;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readOwner   <= OWN_CORE;
            readPending <= 1'b0;
        end else begin
            readPending <= mem_rden;
            if (mem_rden) begin
                readOwner <= copGnt ? OWN_COP : OWN_CORE;
            end
        end
    end

    assign cop_gnt       = copGnt;
    // Reset in the response cycle swallows the pending coprocessor response.
    assign cop_rvalid    = readPending & (readOwner == OWN_COP) & ~reset;
    assign core_readData = mem_q;
    assign cop_rdata     = mem_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed vector table, contention sequence and
// random traffic checked against a cycle-level reference model with a shadow memory.
module tb_dmem_arbiter;

    localparam int N        = 64;
    localparam int AW       = 10;
    localparam int MAX_WAIT = 4;
`ifdef DMEM_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  core_addr, core_writeData, core_readData;
    logic          core_writeEnable, core_readEnable, core_stall;
    logic          cop_req, cop_we, cop_gnt, cop_rvalid;
    logic [N-1:0]  cop_addr, cop_wdata, cop_rdata;
    logic [AW-1:0] mem_address;
    logic [N-1:0]  mem_data, mem_q;
    logic          mem_rden, mem_wren;

    always #5 clk = ~clk;

    dmem_arbiter #(.N(N), .AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .core_addr(core_addr), .core_writeData(core_writeData),
        .core_writeEnable(core_writeEnable), .core_readEnable(core_readEnable),
        .core_readData(core_readData), .core_stall(core_stall),
        .cop_req(cop_req), .cop_we(cop_we), .cop_addr(cop_addr), .cop_wdata(cop_wdata),
        .cop_gnt(cop_gnt), .cop_rvalid(cop_rvalid), .cop_rdata(cop_rdata),
        .mem_address(mem_address), .mem_data(mem_data), .mem_rden(mem_rden),
        .mem_wren(mem_wren), .mem_q(mem_q)
    );

    // Behavioural single-port RAM with one-cycle read latency.
    logic [N-1:0] ram [1<<AW];
    always @(posedge clk) begin
        if (mem_wren) ram[mem_address] <= mem_data;
        if (mem_rden) mem_q <= ram[mem_address];
    end

    // Reference model state.
    logic [N-1:0] shadow [1<<AW];
    int           waitCnt;
    bit           prevCoreRd, prevCopRd;
    logic [N-1:0] prevData;
    int           total = 0;
    int           bad   = 0;

    typedef struct {
        logic          gnt, stall, rden, wren, rvalid;
        logic [AW-1:0] addr;
        logic [N-1:0]  data, coreRd, copRd;
    } obs_t;

    typedef struct {
        logic          rst, cre, cwe;
        logic [N-1:0]  caddr, cwd;
        logic          creq, pwe;
        logic [N-1:0]  paddr, pwd;
        logic          eGnt, eRden, eWren;
        logic [AW-1:0] eAddr;
        logic [N-1:0]  eData;
        logic          eRv;
        int            chkRd;
        logic [N-1:0]  eRdVal;
    } vec_t;

    function automatic logic [N-1:0] initWord(int i);
        return 64'hC0DE_0000_0000_0000 ^ (64'(i) * 64'h9E37_79B9);
    endfunction

    task automatic chk(string name, logic [N-1:0] act, logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic cre, input logic cwe,
                        input logic [N-1:0] caddr, input logic [N-1:0] cwd,
                        input logic creq, input logic pwe,
                        input logic [N-1:0] paddr, input logic [N-1:0] pwd,
                        output obs_t o);
        logic          coreReq, gCore, gCop, eWr, eRd, eStall, eRv;
        logic [AW-1:0] eAddr;
        logic [N-1:0]  eData;
        reset = rst; core_readEnable = cre; core_writeEnable = cwe;
        core_addr = caddr; core_writeData = cwd;
        cop_req = creq; cop_we = pwe; cop_addr = paddr; cop_wdata = pwd;
        @(negedge clk);
        o.gnt = cop_gnt; o.stall = core_stall; o.rden = mem_rden; o.wren = mem_wren;
        o.rvalid = cop_rvalid; o.addr = mem_address; o.data = mem_data;
        o.coreRd = core_readData; o.copRd = cop_rdata;

        // Arbitration rules: core wins contention unless the coprocessor has waited MAX_WAIT cycles.
        coreReq = cre | cwe;
        gCore = 1'b0; gCop = 1'b0;
        if (!rst) begin
            if (coreReq && creq) begin
                if (FAIR && waitCnt >= MAX_WAIT) gCop = 1'b1;
                else gCore = 1'b1;
            end else begin
                gCore = coreReq;
                gCop  = creq;
            end
        end
        eAddr  = gCore ? caddr[AW+2:3] : (gCop ? paddr[AW+2:3] : '0);
        eData  = gCore ? cwd : (gCop ? pwd : '0);
        eWr    = gCore ? cwe : (gCop ? pwe : 1'b0);
        eRd    = (gCore || gCop) && !eWr;
        eStall = FAIR && coreReq && gCop;
        eRv    = prevCopRd && !rst;

        chk("cop_gnt", {63'd0, o.gnt}, {63'd0, gCop});
        chk("core_stall", {63'd0, o.stall}, {63'd0, eStall});
        chk("mem_rden", {63'd0, o.rden}, {63'd0, eRd});
        chk("mem_wren", {63'd0, o.wren}, {63'd0, eWr});
        chk("mem_address", N'(o.addr), N'(eAddr));
        chk("mem_data", o.data, eData);
        chk("cop_rvalid", {63'd0, o.rvalid}, {63'd0, eRv});
        if (prevCoreRd) chk("core_readData", o.coreRd, prevData);
        if (prevCopRd)  chk("cop_rdata", o.copRd, prevData);

        prevCoreRd = gCore && eRd;
        prevCopRd  = gCop && eRd;
        if (eRd) prevData = shadow[eAddr];
        if (eWr) shadow[eAddr] = eData;
        if (rst || !creq || gCop) waitCnt = 0;
        else if (waitCnt < MAX_WAIT) waitCnt = waitCnt + 1;

        $display("t=%0t rst=%b core(r%b w%b a=%h) cop(q%b w%b a=%h) -> gnt=%b stall=%b rden=%b wren=%b addr=%0d rv=%b",
                 $time, rst, cre, cwe, caddr, creq, pwe, paddr,
                 o.gnt, o.stall, o.rden, o.wren, o.addr, o.rvalid);
        @(posedge clk);
        #1;
    endtask

    vec_t vec [15];
    obs_t o;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]    = initWord(i);
            shadow[i] = initWord(i);
        end
        waitCnt = 0; prevCoreRd = 0; prevCopRd = 0; prevData = '0;
        reset = 1'b1; core_readEnable = 0; core_writeEnable = 0; core_addr = '0;
        core_writeData = '0; cop_req = 0; cop_we = 0; cop_addr = '0; cop_wdata = '0;
        @(posedge clk);
        #1;

        //          rst cre cwe caddr       cwd  creq pwe paddr   pwd     gnt rd wr addr data    rv chk rdval
        vec[0]  = '{1, 1, 0, 64'h40, 64'h0, 1, 0, 64'h18, 64'h0,   0, 0, 0, 0,  64'h0,  0, 0, 64'h0};
        vec[1]  = '{0, 1, 0, 64'h40, 64'h0, 0, 0, 64'h0,  64'h0,   0, 1, 0, 8,  64'h0,  0, 0, 64'h0};
        vec[2]  = '{0, 0, 0, 64'h0,  64'h0, 0, 0, 64'h0,  64'h0,   0, 0, 0, 0,  64'h0,  0, 1, initWord(8)};
        vec[3]  = '{0, 0, 0, 64'h0,  64'h0, 1, 1, 64'h18, 64'hAB,  1, 0, 1, 3,  64'hAB, 0, 0, 64'h0};
        vec[4]  = '{0, 0, 0, 64'h0,  64'h0, 0, 0, 64'h0,  64'h0,   0, 0, 0, 0,  64'h0,  0, 0, 64'h0};
        vec[5]  = '{0, 1, 0, 64'h18, 64'h0, 0, 0, 64'h0,  64'h0,   0, 1, 0, 3,  64'h0,  0, 0, 64'h0};
        vec[6]  = '{0, 0, 0, 64'h0,  64'h0, 1, 0, 64'h40, 64'h0,   1, 1, 0, 8,  64'h0,  0, 1, 64'hAB};
        vec[7]  = '{0, 0, 0, 64'h0,  64'h0, 0, 0, 64'h0,  64'h0,   0, 0, 0, 0,  64'h0,  1, 2, initWord(8)};
        vec[8]  = '{0, 0, 0, 64'h0,  64'h0, 0, 0, 64'h0,  64'h0,   0, 0, 0, 0,  64'h0,  0, 0, 64'h0};
        vec[9]  = '{0, 0, 0, 64'h0,  64'h0, 1, 0, 64'h80, 64'h0,   1, 1, 0, 16, 64'h0,  0, 0, 64'h0};
        vec[10] = '{1, 0, 0, 64'h0,  64'h0, 1, 0, 64'h80, 64'h0,   0, 0, 0, 0,  64'h0,  0, 0, 64'h0};
        vec[11] = '{0, 0, 0, 64'h0,  64'h0, 0, 0, 64'h0,  64'h0,   0, 0, 0, 0,  64'h0,  0, 0, 64'h0};
        vec[12] = '{0, 1, 1, 64'h100, 64'h1234_5678_9ABC_DEF0, 1, 0, 64'h40, 64'h0,
                    0, 0, 1, 32, 64'h1234_5678_9ABC_DEF0, 0, 0, 64'h0};
        vec[13] = '{0, 1, 0, 64'h100, 64'h0, 0, 0, 64'h0, 64'h0,   0, 1, 0, 32, 64'h0,  0, 0, 64'h0};
        vec[14] = '{0, 0, 0, 64'h0,  64'h0, 0, 0, 64'h0,  64'h0,   0, 0, 0, 0,  64'h0,  0, 1, 64'h1234_5678_9ABC_DEF0};

        for (int i = 0; i < 15; i++) begin
            step(vec[i].rst, vec[i].cre, vec[i].cwe, vec[i].caddr, vec[i].cwd,
                 vec[i].creq, vec[i].pwe, vec[i].paddr, vec[i].pwd, o);
            chk($sformatf("v%0d.cop_gnt", i), {63'd0, o.gnt}, {63'd0, vec[i].eGnt});
            chk($sformatf("v%0d.mem_rden", i), {63'd0, o.rden}, {63'd0, vec[i].eRden});
            chk($sformatf("v%0d.mem_wren", i), {63'd0, o.wren}, {63'd0, vec[i].eWren});
            chk($sformatf("v%0d.mem_address", i), N'(o.addr), N'(vec[i].eAddr));
            chk($sformatf("v%0d.mem_data", i), o.data, vec[i].eData);
            chk($sformatf("v%0d.cop_rvalid", i), {63'd0, o.rvalid}, {63'd0, vec[i].eRv});
            if (vec[i].chkRd == 1) chk($sformatf("v%0d.core_readData", i), o.coreRd, vec[i].eRdVal);
            if (vec[i].chkRd == 2) chk($sformatf("v%0d.cop_rdata", i), o.copRd, vec[i].eRdVal);
        end

        // Sustained contention: idle first so the wait count starts from zero.
        step(0, 0, 0, '0, '0, 0, 0, '0, '0, o);
        for (int k = 0; k < 20; k++) begin
            logic expCop;
            expCop = FAIR && ((k % (MAX_WAIT + 1)) == MAX_WAIT);
            step(0, 1, 0, 64'h200, '0, 1, 0, 64'h208, '0, o);
            chk($sformatf("contend%0d.cop_gnt", k), {63'd0, o.gnt}, {63'd0, expCop});
            chk($sformatf("contend%0d.core_stall", k), {63'd0, o.stall}, {63'd0, expCop});
        end

        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] ca, pa;
            ca = {$urandom, $urandom};
            pa = {$urandom, $urandom};
            ca[AW+2:3] = AW'($urandom_range(0, 31));
            pa[AW+2:3] = AW'($urandom_range(0, 31));
            step($urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 30,
                 ca, {$urandom, $urandom},
                 $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 40,
                 pa, {$urandom, $urandom}, o);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
